// File: rtl/pwm_compare_if.sv
// Duty-configuration handshake between a config master and pwm_compare.
// The channel index is at least one bit wide so a single-channel build still has a port.
interface pwm_compare_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          cfg_vld;
  logic          cfg_rdy;
  logic [CW-1:0] cfg_chn;
  logic [WIDTH:0] cfg_dty;

  modport master (output cfg_vld, output cfg_chn, output cfg_dty, input cfg_rdy);
  modport slave  (input cfg_vld, input cfg_chn, input cfg_dty, output cfg_rdy);
endinterface

// File: rtl/pwm_compare.sv
// Multi-channel PWM comparator with double-buffered duties applied on the counter wrap.
// Optional complementary outputs with dead-time: define PWM_COMPARE_DEADTIME_EN.
module pwm_compare #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEAD     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [WIDTH-1:0]    cnt,
  input  logic                pls,
  pwm_compare_if.slave        cfg,
  output logic                upd,
  output logic [CHANNELS-1:0] pwm
`ifdef PWM_COMPARE_DEADTIME_EN
  ,output logic [CHANNELS-1:0] pwm_n
`endif
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH:0]      act_q [CHANNELS];
  logic [WIDTH:0]      act_d [CHANNELS];
  logic [WIDTH:0]      pnd_q [CHANNELS];
  logic [WIDTH:0]      pnd_d [CHANNELS];
  logic [CHANNELS-1:0] pen_q, pen_d;
  logic                upd_q, upd_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] cmp_s;
  logic                rdy_s;
  logic                xfer_s;

  // Ready per addressed channel; indices beyond CHANNELS are always ready and dropped.
  always_comb begin
    rdy_s = 1'b1;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (cfg.cfg_chn == CW'(ch)) begin
        rdy_s = ~pen_q[ch] | pls;
      end else begin
        rdy_s = rdy_s;
      end
    end
  end

  assign cfg.cfg_rdy = rdy_s & ~rst;
  assign xfer_s      = cfg.cfg_vld & rdy_s;

  // Apply on wrap uses the old pending value, then a same-cycle write refills pending.
  always_comb begin
    act_d = act_q;
    pnd_d = pnd_q;
    pen_d = pen_q;
    upd_d = 1'b0;
    cmp_s = {CHANNELS{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (pls && pen_q[ch]) begin
        act_d[ch] = pnd_q[ch];
        pen_d[ch] = 1'b0;
        upd_d     = 1'b1;
      end else begin
        act_d[ch] = act_q[ch];
      end
      if (xfer_s && (cfg.cfg_chn == CW'(ch))) begin
        pnd_d[ch] = cfg.cfg_dty;
        pen_d[ch] = 1'b1;
      end else begin
        pnd_d[ch] = pnd_d[ch];
      end
      cmp_s[ch] = ({1'b0, cnt} < act_q[ch]);
    end
  end

  // Duty double-buffer state and update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        act_q[ch] <= {(WIDTH+1){1'b0}};
        pnd_q[ch] <= {(WIDTH+1){1'b0}};
      end
      pen_q <= {CHANNELS{1'b0}};
      upd_q <= 1'b0;
    end else begin
      act_q <= act_d;
      pnd_q <= pnd_d;
      pen_q <= pen_d;
      upd_q <= upd_d;
    end
  end

`ifdef PWM_COMPARE_DEADTIME_EN
  localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

  logic [CHANNELS-1:0] r_q, r_d;
  logic [CHANNELS-1:0] pwmn_q, pwmn_d;
  logic [DW-1:0]       dt_q [CHANNELS];
  logic [DW-1:0]       dt_d [CHANNELS];

  // Any edge of the raw compare reloads the dead-time; both outputs stay low until it drains.
  always_comb begin
    r_d    = r_q;
    dt_d   = dt_q;
    pwm_d  = pwm_q;
    pwmn_d = pwmn_q;
    if (ena) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_d[ch] = cmp_s[ch];
        if (cmp_s[ch] != r_q[ch]) begin
          dt_d[ch] = DW'(DEAD);
        end else if (dt_q[ch] != {DW{1'b0}}) begin
          dt_d[ch] = dt_q[ch] - DW'(1);
        end else begin
          dt_d[ch] = dt_q[ch];
        end
        pwm_d[ch]  =  r_d[ch] & (dt_d[ch] == {DW{1'b0}});
        pwmn_d[ch] = ~r_d[ch] & (dt_d[ch] == {DW{1'b0}});
      end
    end else begin
      pwm_d = pwm_q;
    end
  end

  // Raw compare, dead-time counters and both output phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        dt_q[ch] <= DW'(DEAD);
      end
      r_q    <= {CHANNELS{1'b0}};
      pwm_q  <= {CHANNELS{1'b0}};
      pwmn_q <= {CHANNELS{1'b0}};
    end else begin
      dt_q   <= dt_d;
      r_q    <= r_d;
      pwm_q  <= pwm_d;
      pwmn_q <= pwmn_d;
    end
  end

  assign pwm_n = pwmn_q;
`else
  logic [31:0] unused_dead_s;
  assign unused_dead_s = 32'(DEAD);

  // Plain compare, held while the counter is paused.
  always_comb begin
    if (ena) begin
      pwm_d = cmp_s;
    end else begin
      pwm_d = pwm_q;
    end
  end

  // Registered compare output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= {CHANNELS{1'b0}};
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  assign pwm = pwm_q;
  assign upd = upd_q;
endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: duty table, handshake corner sequences,
// mid-period reset and randomized traffic against a cycle-level reference model.
module tb_pwm_compare;
  localparam int W    = 4;
  localparam int CH   = 4;
  localparam int DEAD = 2;
  localparam int MAXV = 9;
  localparam int PER  = MAXV + 1;

  typedef struct {
    int chn;
    int dty;
    int exp_hi;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          pls;
  logic [W-1:0]  cnt;
  logic          upd;
  logic [CH-1:0] pwm;
`ifdef PWM_COMPARE_DEADTIME_EN
  logic [CH-1:0] pwm_n;
  logic [CH-1:0] m_r;
  logic [CH-1:0] m_pwmn;
  int            m_since [CH];
`endif

  int vectors     = 0;
  int miscompares = 0;

  int            cnt_v;
  logic [W:0]    m_act [CH];
  logic [W:0]    m_pnd [CH];
  logic          m_pen [CH];
  logic [CH-1:0] m_pwm;
  logic          m_upd;
  logic          last_acc;
  logic          last_pls;

  pwm_compare_if #(.WIDTH(W), .CHANNELS(CH)) cfg_if ();

  pwm_compare #(.WIDTH(W), .CHANNELS(CH), .DEAD(DEAD)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .cnt  (cnt),
    .pls  (pls),
    .cfg  (cfg_if.slave),
    .upd  (upd),
    .pwm  (pwm)
`ifdef PWM_COMPARE_DEADTIME_EN
    ,.pwm_n(pwm_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_act[c] = '0;
      m_pnd[c] = '0;
      m_pen[c] = 1'b0;
`ifdef PWM_COMPARE_DEADTIME_EN
      m_since[c] = 0;
`endif
    end
    m_pwm = '0;
    m_upd = 1'b0;
    cnt_v = 0;
`ifdef PWM_COMPARE_DEADTIME_EN
    m_r    = '0;
    m_pwmn = '0;
`endif
  endtask

  // One clock: drive counter and config, check ready, advance model, check outputs.
  task automatic cycle(input logic e, input logic v, input int chn, input int d);
    logic p;
    logic exp_rdy;
    logic cmp;
    p = e && (cnt_v == MAXV);
    ena = e;
    pls = p;
    cnt = W'(cnt_v);
    cfg_if.cfg_vld = v;
    cfg_if.cfg_chn = chn[1:0];
    cfg_if.cfg_dty = (W+1)'(d);
    #1;
    exp_rdy = (chn >= CH) ? 1'b1 : (!m_pen[chn] || p);
    check("cfg_rdy", 64'(cfg_if.cfg_rdy), 64'(exp_rdy));
    last_acc = v && exp_rdy;
    last_pls = p;
    if (e) begin
      for (int c = 0; c < CH; c++) begin
        cmp = (cnt_v < int'(m_act[c]));
`ifdef PWM_COMPARE_DEADTIME_EN
        if (cmp != m_r[c]) m_since[c] = 0;
        else m_since[c] = m_since[c] + 1;
        m_r[c]    = cmp;
        m_pwm[c]  = cmp && (m_since[c] >= DEAD);
        m_pwmn[c] = !cmp && (m_since[c] >= DEAD);
`else
        m_pwm[c] = cmp;
`endif
      end
    end
    m_upd = 1'b0;
    if (p) begin
      for (int c = 0; c < CH; c++) begin
        if (m_pen[c]) begin
          m_act[c] = m_pnd[c];
          m_pen[c] = 1'b0;
          m_upd    = 1'b1;
        end
      end
    end
    if (last_acc && chn < CH) begin
      m_pnd[chn] = (W+1)'(d);
      m_pen[chn] = 1'b1;
    end
    if (e) cnt_v = p ? 0 : cnt_v + 1;
    @(posedge clk);
    #1;
    check("pwm", 64'(pwm), 64'(m_pwm));
    check("upd", 64'(upd), 64'(m_upd));
`ifdef PWM_COMPARE_DEADTIME_EN
    check("pwm_n", 64'(pwm_n), 64'(m_pwmn));
    check("overlap", 64'(|(pwm & pwm_n)), 64'(0));
`endif
  endtask

  task automatic write_duty(input int chn, input int d);
    int g;
    if (cnt_v == MAXV) cycle(1'b1, 1'b0, 0, 0);
    g = 0;
    last_acc = 1'b0;
    while (!last_acc && g < 2 * PER) begin
      cycle(1'b1, 1'b1, chn, d);
      g++;
    end
    check("write_accept", 64'(last_acc), 64'(1));
  endtask

  task automatic wait_start();
    int g;
    g = 0;
    while (cnt_v != 0 && g < 2 * PER) begin
      cycle(1'b1, 1'b0, 0, 0);
      g++;
    end
    check("wait_period_start", 64'(cnt_v), 64'(0));
  endtask

  task automatic count_period(input int chn, output int hi);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      cycle(1'b1, 1'b0, 0, 0);
      hi += int'(pwm[chn]);
    end
  endtask

  vec_t tbl [9];

  initial begin
    int hi;
    int g;
    tbl[0] = '{0, 3, 3};
    tbl[1] = '{1, 0, 0};
    tbl[2] = '{1, 10, 10};
    tbl[3] = '{0, 9, 9};
    tbl[4] = '{0, 1, 1};
    tbl[5] = '{2, 31, 10};
    tbl[6] = '{3, 16, 10};
    tbl[7] = '{0, 0, 0};
    tbl[8] = '{3, 5, 5};

    rst = 1'b1;
    ena = 1'b0;
    pls = 1'b0;
    cnt = '0;
    cfg_if.cfg_vld = 1'b0;
    cfg_if.cfg_chn = '0;
    cfg_if.cfg_dty = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm", 64'(pwm), 64'(0));
    check("reset_upd", 64'(upd), 64'(0));
    check("reset_rdy", 64'(cfg_if.cfg_rdy), 64'(0));
    rst = 1'b0;

    // Duty table: write, let the wrap apply it, count high cycles over one period.
    for (int i = 0; i < 9; i++) begin
      write_duty(tbl[i].chn, tbl[i].dty);
      wait_start();
      count_period(tbl[i].chn, hi);
`ifndef PWM_COMPARE_DEADTIME_EN
      check("duty_high_cycles", 64'(hi), 64'(tbl[i].exp_hi));
`endif
    end

    // Second write to a pending channel stalls until the wrap, lands one period later.
    write_duty(2, 4);
    g = 0;
    last_acc = 1'b0;
    while (!last_acc && g < 2 * PER) begin
      cycle(1'b1, 1'b1, 2, 7);
      g++;
    end
    check("stall_until_pls", 64'(last_acc && last_pls), 64'(1));
    count_period(2, hi);
`ifndef PWM_COMPARE_DEADTIME_EN
    check("ch2_first_period", 64'(hi), 64'(4));
`endif
    count_period(2, hi);
`ifndef PWM_COMPARE_DEADTIME_EN
    check("ch2_second_period", 64'(hi), 64'(7));
`endif

    // Write in the wrap cycle to a pending channel: old pending applies first.
    write_duty(3, 5);
    g = 0;
    while (cnt_v != MAXV && g < 2 * PER) begin
      cycle(1'b1, 1'b0, 0, 0);
      g++;
    end
    cycle(1'b1, 1'b1, 3, 7);
    check("pls_cycle_accept", 64'(last_acc && last_pls), 64'(1));
    count_period(3, hi);
`ifndef PWM_COMPARE_DEADTIME_EN
    check("ch3_period_n1", 64'(hi), 64'(5));
`endif
    count_period(3, hi);
`ifndef PWM_COMPARE_DEADTIME_EN
    check("ch3_period_n2", 64'(hi), 64'(7));
`endif

    // Mid-period reset with a pending duty on ch0.
    write_duty(0, 6);
    cycle(1'b1, 1'b0, 0, 0);
    check("pre_reset_pwm_active", 64'(pwm != '0), 64'(1));
    rst = 1'b1;
    #1;
    check("async_reset_pwm", 64'(pwm), 64'(0));
    check("async_reset_upd", 64'(upd), 64'(0));
    check("async_reset_rdy", 64'(cfg_if.cfg_rdy), 64'(0));
`ifdef PWM_COMPARE_DEADTIME_EN
    check("async_reset_pwm_n", 64'(pwm_n), 64'(0));
`endif
    ena = 1'b0;
    pls = 1'b0;
    cfg_if.cfg_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    count_period(0, hi);
    check("post_reset_period1", 64'(hi), 64'(0));
    count_period(0, hi);
    check("post_reset_period2", 64'(hi), 64'(0));

    // Randomized traffic with ena gaps.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
